riscv_i32_dmem_access_sequencer: RTL and testbench

- Sits between the execute stage and data memory, directly upstream of the dmem read-data aligner.
- Accepts one load/store at a time and drives the registered dmem access request.
- Splits misaligned accesses into two aligned word transactions.
- Supplies the aligner's control fields (rotation, byte clear/enable, sign extend) and holds last_data across phases for reassembly.

---
 rtl/riscv_i32_dmem_access_sequencer_pkg.sv | 39 +++
 rtl/riscv_i32_dmem_lane_decode.sv | 41 ++++
 rtl/riscv_i32_dmem_access_sequencer.sv | 175 +++++++++++++++++
 tb/tb_riscv_i32_dmem_access_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_i32_dmem_access_sequencer_pkg.sv
// rtl/riscv_i32_dmem_access_sequencer_pkg.sv - shared riscv_i32 dmem types for the access sequencer
package riscv_i32_dmem_access_sequencer_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS_FIRST,
        ST_ACCESS_FINAL,
        ST_FAULT
    } seq_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [3:0]  byte_enable;
        logic        read_enable;
        logic        write_enable;
        logic [31:0] write_data;
    } dmem_access_req_t;

    typedef struct packed {
        logic [1:0] read_data_rotation;
        logic [3:0] read_data_byte_clear;
        logic [3:0] read_data_byte_enable;
        logic       sign_extend_byte;
        logic       sign_extend_half;
        logic       multicycle;
    } dmem_request_t;

    // Rotate left by whole bytes so LSB-justified store data lands on its bus lanes.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] n);
        logic [63:0] pair;
        pair = {d, d} << {n, 3'b000};
        return pair[63:32];
    endfunction

endpackage

// File: rtl/riscv_i32_dmem_lane_decode.sv
// rtl/riscv_i32_dmem_lane_decode.sv - size/offset to bus lane and aligner byte-enable decode
module riscv_i32_dmem_lane_decode
    import riscv_i32_dmem_access_sequencer_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] off,
    input  logic       is_load,
    input  logic       unsigned_req,
    output logic [7:0] m8,
    output logic [3:0] en_single,
    output logic [3:0] en_first,
    output logic [3:0] en_second,
    output logic       sign_ext_byte,
    output logic       sign_ext_half
);

    logic [3:0] mask;
    logic [7:0] hi_pair;
    logic [3:0] hi_rotr;

    always_comb begin
        case (size)
            SIZE_BYTE: mask = 4'b0001;
            SIZE_HALF: mask = 4'b0011;
            default:   mask = 4'b1111;
        endcase
    end

    assign m8 = {4'b0000, mask} << off;

    // Second-word lanes mapped back into the aligner's rotated byte positions.
    assign hi_pair = {m8[7:4], m8[7:4]} >> off;
    assign hi_rotr = hi_pair[3:0];

    assign en_single     = mask;
    assign en_first      = mask & ~hi_rotr;
    assign en_second     = mask & hi_rotr;
    assign sign_ext_byte = is_load & (size == SIZE_BYTE) & ~unsigned_req;
    assign sign_ext_half = is_load & (size == SIZE_HALF) & ~unsigned_req;

endmodule

// File: rtl/riscv_i32_dmem_access_sequencer.sv
// rtl/riscv_i32_dmem_access_sequencer.sv - load/store sequencer splitting misaligned accesses into two word phases
module riscv_i32_dmem_access_sequencer
    import riscv_i32_dmem_access_sequencer_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exec_req_valid,
    input  logic        exec_req_load,
    input  logic        exec_req_store,
    input  logic [1:0]  exec_req_size,
    input  logic        exec_req_unsigned,
    input  logic [31:0] exec_req_address,
    input  logic [31:0] exec_req_write_data,
    output logic        exec_ready,
    output logic        exec_done,
    output logic        exec_misaligned_load,
    output logic        exec_misaligned_store,
    output logic [31:0] dmem_access_req__address,
    output logic [3:0]  dmem_access_req__byte_enable,
    output logic        dmem_access_req__read_enable,
    output logic        dmem_access_req__write_enable,
    output logic [31:0] dmem_access_req__write_data,
    input  logic        dmem_access_resp__wait,
    input  logic [31:0] dmem_read_data,
    output logic [31:0] last_data,
    output logic [1:0]  dmem_request__read_data_rotation,
    output logic [3:0]  dmem_request__read_data_byte_clear,
    output logic [3:0]  dmem_request__read_data_byte_enable,
    output logic        dmem_request__sign_extend_byte,
    output logic        dmem_request__sign_extend_half,
    output logic        dmem_request__multicycle
);

    seq_state_t       state, state_nxt;
    dmem_access_req_t bus_q;
    dmem_request_t    ctl_q;
    logic [31:0]      last_data_q;
    logic [3:0]       be_second_q, en_second_q;
    logic             seb_final_q, seh_final_q, load_q;

    logic [1:0] off;
    logic [7:0] lane_m8;
    logic [3:0] en_single, en_first, en_second;
    logic       seb, seh, split, accept, req_is_load, req_is_store, to_fault;

    riscv_i32_dmem_lane_decode u_lane_decode (
        .size          (exec_req_size),
        .off           (off),
        .is_load       (req_is_load),
        .unsigned_req  (exec_req_unsigned),
        .m8            (lane_m8),
        .en_single     (en_single),
        .en_first      (en_first),
        .en_second     (en_second),
        .sign_ext_byte (seb),
        .sign_ext_half (seh)
    );

    assign off          = exec_req_address[1:0];
    assign req_is_load  = exec_req_load;
    assign req_is_store = exec_req_store & ~exec_req_load;
    assign accept       = exec_req_valid & (state == ST_IDLE) & (exec_req_load | exec_req_store);
    assign split        = |lane_m8[7:4];
    assign to_fault     = split & ~ALLOW_MISALIGNED;

    always_comb begin
        state_nxt             = state;
        exec_done             = 1'b0;
        exec_misaligned_load  = 1'b0;
        exec_misaligned_store = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!split)        state_nxt = ST_ACCESS_FINAL;
                    else if (to_fault) state_nxt = ST_FAULT;
                    else               state_nxt = ST_ACCESS_FIRST;
                end
            end
            ST_ACCESS_FIRST: begin
                if (!dmem_access_resp__wait) state_nxt = ST_ACCESS_FINAL;
            end
            ST_ACCESS_FINAL: begin
                if (!dmem_access_resp__wait) begin
                    state_nxt = ST_IDLE;
                    exec_done = 1'b1;
                end
            end
            ST_FAULT: begin
                state_nxt             = ST_IDLE;
                exec_done             = 1'b1;
                exec_misaligned_load  = load_q;
                exec_misaligned_store = ~load_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bus_q       <= '0;
            ctl_q       <= '0;
            last_data_q <= '0;
            be_second_q <= '0;
            en_second_q <= '0;
            seb_final_q <= 1'b0;
            seh_final_q <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus_q.address                 <= {exec_req_address[31:2], 2'b00};
                        bus_q.byte_enable             <= to_fault ? 4'b0000 : lane_m8[3:0];
                        bus_q.read_enable             <= req_is_load & ~to_fault;
                        bus_q.write_enable            <= req_is_store & ~to_fault;
                        bus_q.write_data              <= rotl_bytes(exec_req_write_data, off);
                        ctl_q.read_data_rotation      <= off;
                        ctl_q.read_data_byte_clear    <= 4'b1111;
                        ctl_q.read_data_byte_enable   <= split ? en_first : en_single;
                        ctl_q.sign_extend_byte        <= seb & ~split;
                        ctl_q.sign_extend_half        <= seh & ~split;
                        ctl_q.multicycle              <= split & ALLOW_MISALIGNED;
                        be_second_q                   <= lane_m8[7:4];
                        en_second_q                   <= en_second;
                        seb_final_q                   <= seb;
                        seh_final_q                   <= seh;
                        load_q                        <= req_is_load;
                    end
                end
                ST_ACCESS_FIRST: begin
                    // First word's aligned bytes are parked so the aligner can merge the second word.
                    if (!dmem_access_resp__wait) begin
                        last_data_q                   <= dmem_read_data;
                        bus_q.address                 <= bus_q.address + 32'd4;
                        bus_q.byte_enable             <= be_second_q;
                        ctl_q.read_data_byte_clear    <= 4'b0000;
                        ctl_q.read_data_byte_enable   <= en_second_q;
                        ctl_q.sign_extend_byte        <= seb_final_q;
                        ctl_q.sign_extend_half        <= seh_final_q;
                    end
                end
                ST_ACCESS_FINAL: begin
                    if (!dmem_access_resp__wait) begin
                        bus_q.read_enable             <= 1'b0;
                        bus_q.write_enable            <= 1'b0;
                        bus_q.byte_enable             <= 4'b0000;
                        ctl_q.sign_extend_byte        <= 1'b0;
                        ctl_q.sign_extend_half        <= 1'b0;
                        ctl_q.multicycle              <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign exec_ready                          = (state == ST_IDLE);
    assign dmem_access_req__address            = bus_q.address;
    assign dmem_access_req__byte_enable        = bus_q.byte_enable;
    assign dmem_access_req__read_enable        = bus_q.read_enable;
    assign dmem_access_req__write_enable       = bus_q.write_enable;
    assign dmem_access_req__write_data         = bus_q.write_data;
    assign last_data                           = last_data_q;
    assign dmem_request__read_data_rotation    = ctl_q.read_data_rotation;
    assign dmem_request__read_data_byte_clear  = ctl_q.read_data_byte_clear;
    assign dmem_request__read_data_byte_enable = ctl_q.read_data_byte_enable;
    assign dmem_request__sign_extend_byte      = ctl_q.sign_extend_byte;
    assign dmem_request__sign_extend_half      = ctl_q.sign_extend_half;
    assign dmem_request__multicycle            = ctl_q.multicycle;

endmodule

// File: tb/tb_riscv_i32_dmem_access_sequencer.sv
// tb/tb_riscv_i32_dmem_access_sequencer.sv - self-checking bench for the dmem access sequencer
module tb_riscv_i32_dmem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid, valid2, ld, st, uns, dmem_wait, mem_init;
    logic [1:0]  size;
    logic [31:0] addr, wdata, dmem_read_data;

    logic        exec_ready, exec_done, mis_ld, mis_st, re, we, seb, seh, mc;
    logic [31:0] bus_addr, bus_wd, last_data;
    logic [3:0]  be, clr, en;
    logic [1:0]  rot;

    logic        d2_ready, d2_done, d2_mis_ld, d2_mis_st, d2_re, d2_we, d2_seb, d2_seh, d2_mc;
    logic [31:0] d2_addr, d2_wd, d2_last;
    logic [3:0]  d2_be, d2_clr, d2_en;
    logic [1:0]  d2_rot;

    logic [31:0] bmem [64];
    logic [31:0] init_mem [64];
    logic [7:0]  rmem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_i32_dmem_access_sequencer dut (
        .clk(clk), .reset_n(reset_n), .exec_req_valid(valid), .exec_req_load(ld), .exec_req_store(st),
        .exec_req_size(size), .exec_req_unsigned(uns), .exec_req_address(addr), .exec_req_write_data(wdata),
        .exec_ready(exec_ready), .exec_done(exec_done), .exec_misaligned_load(mis_ld), .exec_misaligned_store(mis_st),
        .dmem_access_req__address(bus_addr), .dmem_access_req__byte_enable(be),
        .dmem_access_req__read_enable(re), .dmem_access_req__write_enable(we),
        .dmem_access_req__write_data(bus_wd), .dmem_access_resp__wait(dmem_wait),
        .dmem_read_data(dmem_read_data), .last_data(last_data),
        .dmem_request__read_data_rotation(rot), .dmem_request__read_data_byte_clear(clr),
        .dmem_request__read_data_byte_enable(en), .dmem_request__sign_extend_byte(seb),
        .dmem_request__sign_extend_half(seh), .dmem_request__multicycle(mc)
    );

    riscv_i32_dmem_access_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .exec_req_valid(valid2), .exec_req_load(ld), .exec_req_store(st),
        .exec_req_size(size), .exec_req_unsigned(uns), .exec_req_address(addr), .exec_req_write_data(wdata),
        .exec_ready(d2_ready), .exec_done(d2_done), .exec_misaligned_load(d2_mis_ld), .exec_misaligned_store(d2_mis_st),
        .dmem_access_req__address(d2_addr), .dmem_access_req__byte_enable(d2_be),
        .dmem_access_req__read_enable(d2_re), .dmem_access_req__write_enable(d2_we),
        .dmem_access_req__write_data(d2_wd), .dmem_access_resp__wait(dmem_wait),
        .dmem_read_data(32'h0), .last_data(d2_last),
        .dmem_request__read_data_rotation(d2_rot), .dmem_request__read_data_byte_clear(d2_clr),
        .dmem_request__read_data_byte_enable(d2_en), .dmem_request__sign_extend_byte(d2_seb),
        .dmem_request__sign_extend_half(d2_seh), .dmem_request__multicycle(d2_mc)
    );

    // Downstream aligner: rotate right, take enabled bytes, clear or keep held bytes, then sign extend.
    function automatic logic [31:0] aligner(input logic [31:0] word, input logic [1:0] r, input logic [3:0] c,
                                            input logic [3:0] e, input logic sb, input logic sh, input logic [31:0] held);
        logic [63:0] pair;
        logic [31:0] o;
        pair = {word, word} >> (8 * r);
        for (int i = 0; i < 4; i++)
            o[8*i +: 8] = e[i] ? pair[8*i +: 8] : (c[i] ? 8'h00 : held[8*i +: 8]);
        if (sb) o = {{24{o[7]}}, o[7:0]};
        if (sh) o = {{16{o[15]}}, o[15:0]};
        return o;
    endfunction

    always_comb dmem_read_data = aligner(bmem[bus_addr[7:2]], rot, clr, en, seb, seh, last_data);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) bmem[i] <= init_mem[i];
        end else if (we && !dmem_wait) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) bmem[bus_addr[7:2]][8*i +: 8] <= bus_wd[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld, st, uns, split;
        logic [1:0]  size, rot;
        logic [31:0] addr, wdata, a0, a1, wd, res;
        logic [3:0]  be0, be1, en0, en1;
    } vec_t;

    function automatic vec_t mk(input logic l, input logic s, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d, input logic sp,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [3:0] be0,
                                input logic [3:0] be1, input logic [3:0] en0, input logic [3:0] en1,
                                input logic [1:0] r, input logic [31:0] wd, input logic [31:0] res);
        vec_t v;
        v.ld = l; v.st = s; v.size = sz; v.uns = u; v.addr = a; v.wdata = d; v.split = sp;
        v.a0 = a0; v.a1 = a1; v.be0 = be0; v.be1 = be1; v.en0 = en0; v.en1 = en1;
        v.rot = r; v.wd = wd; v.res = res;
        return v;
    endfunction

    task automatic load_mem();
        @(negedge clk); mem_init = 1'b1;
        @(negedge clk); mem_init = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        @(negedge clk);
        dmem_wait = 1'b0; valid = 1'b1;
        ld = v.ld; st = v.st; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
        #1 chk($sformatf("v%0d.ready", k), exec_ready, 1);
        @(negedge clk); valid = 1'b0; #1;
        chk($sformatf("v%0d.addr0", k), bus_addr, v.a0);
        chk($sformatf("v%0d.be0", k), be, v.be0);
        chk($sformatf("v%0d.en0", k), en, v.en0);
        chk($sformatf("v%0d.clr0", k), clr, 4'hF);
        chk($sformatf("v%0d.rot", k), rot, v.rot);
        chk($sformatf("v%0d.re", k), re, v.ld);
        chk($sformatf("v%0d.we", k), we, v.st & ~v.ld);
        chk($sformatf("v%0d.wd", k), bus_wd, v.wd);
        chk($sformatf("v%0d.mc0", k), mc, v.split);
        chk($sformatf("v%0d.done0", k), exec_done, !v.split);
        if (v.split) begin
            @(negedge clk); #1;
            chk($sformatf("v%0d.addr1", k), bus_addr, v.a1);
            chk($sformatf("v%0d.be1", k), be, v.be1);
            chk($sformatf("v%0d.en1", k), en, v.en1);
            chk($sformatf("v%0d.clr1", k), clr, 4'h0);
            chk($sformatf("v%0d.mc1", k), mc, 1);
            chk($sformatf("v%0d.wd1", k), bus_wd, v.wd);
            chk($sformatf("v%0d.done1", k), exec_done, 1);
        end
        if (v.ld) chk($sformatf("v%0d.result", k), dmem_read_data, v.res);
    endtask

    task automatic fault_case(input logic l, input logic s, input logic [1:0] sz, input logic [31:0] a,
                              input logic expect_fault, input int k);
        @(negedge clk);
        dmem_wait = 1'b0; valid2 = 1'b1; ld = l; st = s; size = sz; uns = 1'b0; addr = a; wdata = 32'h0;
        #1 chk($sformatf("f%0d.ready", k), d2_ready, 1);
        @(negedge clk); valid2 = 1'b0; #1;
        chk($sformatf("f%0d.done", k), d2_done, 1);
        chk($sformatf("f%0d.mis_ld", k), d2_mis_ld, expect_fault & l);
        chk($sformatf("f%0d.mis_st", k), d2_mis_st, expect_fault & ~l);
        chk($sformatf("f%0d.rw", k), {d2_re, d2_we}, expect_fault ? 2'b00 : {l, ~l});
        chk($sformatf("f%0d.be", k), d2_be, expect_fault ? 4'h0 : 4'hF);
        @(negedge clk); #1;
        chk($sformatf("f%0d.done_after", k), {d2_done, d2_mis_ld, d2_mis_st}, 3'b000);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic u);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[(a + i) & 32'hFF];
        if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic rand_txn(input int k);
        logic        l, s, u, done;
        logic [1:0]  sz;
        logic [31:0] a, d, exp_v, got;
        int          n, phases, cyc;
        l  = 1'($urandom_range(0, 1));
        s  = ~l | ($urandom_range(0, 3) == 0);
        sz = 2'($urandom_range(0, 3));
        u  = 1'($urandom_range(0, 1));
        a  = $urandom;
        d  = $urandom;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_v = '0;
        if (l) exp_v = ref_load(a, n, u);
        else for (int i = 0; i < n; i++) rmem[(a + i) & 32'hFF] = d[8*i +: 8];
        @(negedge clk);
        valid = 1'b1; ld = l; st = s; size = sz; uns = u; addr = a; wdata = d;
        dmem_wait = ($urandom_range(0, 2) == 0);
        @(negedge clk); valid = 1'b0;
        done = 1'b0; phases = 0; cyc = 0; got = '0;
        while (!done && cyc < 40) begin
            dmem_wait = ($urandom_range(0, 2) == 0);
            #1;
            if ((re || we) && !dmem_wait) phases++;
            if (exec_done) begin
                done = 1'b1;
                got  = dmem_read_data;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("r%0d.done", k), done, 1);
        chk($sformatf("r%0d.phases", k), phases, (((a % 4) + n) > 4) ? 2 : 1);
        if (l) chk($sformatf("r%0d.load", k), got, exp_v);
    endtask

    vec_t vt [12];

    initial begin
        valid = 0; valid2 = 0; ld = 0; st = 0; uns = 0; size = 0; addr = 0; wdata = 0;
        dmem_wait = 0; mem_init = 0;
        for (int i = 0; i < 64; i++) init_mem[i] = 32'h0;
        init_mem[0]  = 32'hDDCCBBAA;
        init_mem[1]  = 32'h44332211;
        init_mem[63] = 32'h88776655;

        vt[0]  = mk(1, 0, 2, 0, 32'h100, 0, 0, 32'h100, 0, 4'b1111, 0, 4'b1111, 0, 0, 0, 32'hDDCCBBAA);
        vt[1]  = mk(1, 0, 0, 0, 32'h103, 0, 0, 32'h100, 0, 4'b1000, 0, 4'b0001, 0, 3, 0, 32'hFFFFFFDD);
        vt[2]  = mk(1, 0, 0, 1, 32'h003, 0, 0, 32'h000, 0, 4'b1000, 0, 4'b0001, 0, 3, 0, 32'h000000DD);
        vt[3]  = mk(1, 0, 1, 1, 32'h002, 0, 0, 32'h000, 0, 4'b1100, 0, 4'b0011, 0, 2, 0, 32'h0000DDCC);
        vt[4]  = mk(1, 0, 1, 0, 32'h102, 0, 0, 32'h100, 0, 4'b1100, 0, 4'b0011, 0, 2, 0, 32'hFFFFDDCC);
        vt[5]  = mk(1, 0, 2, 0, 32'h201, 0, 1, 32'h200, 32'h204, 4'b1110, 4'b0001, 4'b0111, 4'b1000, 1, 0, 32'h11DDCCBB);
        vt[6]  = mk(1, 0, 1, 0, 32'h003, 0, 1, 32'h000, 32'h004, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 3, 0, 32'h000011DD);
        vt[7]  = mk(1, 0, 2, 0, 32'hFFFFFFFE, 0, 1, 32'hFFFFFFFC, 32'h0, 4'b1100, 4'b0011, 4'b0011, 4'b1100, 2, 0, 32'hBBAA8877);
        vt[8]  = mk(1, 1, 2, 0, 32'h100, 0, 0, 32'h100, 0, 4'b1111, 0, 4'b1111, 0, 0, 0, 32'hDDCCBBAA);
        vt[9]  = mk(0, 1, 1, 0, 32'h003, 32'h0000BEEF, 1, 32'h000, 32'h004, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 3, 32'hEF0000BE, 0);
        vt[10] = mk(0, 1, 2, 0, 32'h008, 32'h12345678, 0, 32'h008, 0, 4'b1111, 0, 4'b1111, 0, 0, 32'h12345678, 0);
        vt[11] = mk(0, 1, 0, 0, 32'h006, 32'hFFFFFFA5, 0, 32'h004, 0, 4'b0100, 0, 4'b0001, 0, 2, 32'hFFA5FFFF, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst.ready", exec_ready, 1);
        chk("rst.enables", {re, we, be, exec_done, mis_ld, mis_st}, 0);
        chk("rst.addr", bus_addr, 0);
        chk("rst.wd", bus_wd, 0);
        chk("rst.last", last_data, 0);
        chk("rst.aligner", {rot, clr, en, seb, seh, mc}, 0);
        @(negedge clk); reset_n = 1'b1;
        load_mem();

        for (int k = 0; k < 12; k++) run_vec(vt[k], k);
        @(negedge clk); #1;
        chk("mem.w0", bmem[0], 32'hEFCCBBAA);
        chk("mem.w1", bmem[1], 32'h44A522BE);
        chk("mem.w2", bmem[2], 32'h12345678);

        // Signed byte load held off by three wait cycles, with a second request pending meanwhile.
        @(negedge clk);
        dmem_wait = 1; valid = 1; ld = 1; st = 0; size = 0; uns = 0; addr = 32'h103; wdata = 0;
        @(negedge clk);
        addr = 32'h200; size = 2;
        for (int c = 0; c < 4; c++) begin
            dmem_wait = (c < 3);
            #1;
            chk($sformatf("hold%0d.be", c), be, 4'b1000);
            chk($sformatf("hold%0d.ready", c), exec_ready, 0);
            chk($sformatf("hold%0d.done", c), exec_done, c == 3);
            if (c == 3) begin
                chk("hold.rot", rot, 3);
                chk("hold.seb", seb, 1);
                chk("hold.result", dmem_read_data, 32'hFFFFFFEF);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk); valid = 0; #1;
        chk("busy.not_taken", {exec_ready, re}, 2'b10);

        fault_case(1, 0, 2, 32'h2, 1, 0);
        fault_case(0, 1, 1, 32'h7, 1, 1);
        fault_case(1, 0, 2, 32'h4, 0, 2);

        // Reset while the first phase of a split load is stalled.
        @(negedge clk);
        dmem_wait = 1; valid = 1; ld = 1; st = 0; size = 2; uns = 0; addr = 32'h201;
        @(negedge clk); valid = 0; #1;
        chk("rmid.first_be", {mc, be}, 5'b11110);
        reset_n = 1'b0; #1;
        chk("rmid.ready", exec_ready, 1);
        chk("rmid.idle_bus", {re, we, be, exec_done, mc}, 0);
        chk("rmid.last", last_data, 0);
        @(negedge clk); reset_n = 1'b1; dmem_wait = 0; #1;
        chk("rmid.no_done", exec_done, 0);
        run_vec(mk(1, 0, 2, 0, 32'h008, 0, 0, 32'h008, 0, 4'b1111, 0, 4'b1111, 0, 0, 0, 32'h12345678), 99);

        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        for (int i = 0; i < 256; i++) rmem[i] = init_mem[i / 4][8*(i % 4) +: 8];
        load_mem();
        for (int k = 0; k < 400; k++) rand_txn(k);
        @(negedge clk); dmem_wait = 0;
        @(negedge clk); #1;
        for (int i = 0; i < 64; i++)
            chk($sformatf("rmem.w%0d", i), bmem[i], {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
